// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way set-associative write-back cache controller (optional CACHE_STATS_EN hit/miss counters)
module cache_ctrl_nway #(
    parameter int NWAYS         = 4,
    parameter int NSETS         = 16,
    parameter int WORDS_PER_BLK = 4,
    parameter int WRD_WIDTH     = 32,
    parameter int PA_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cpu_req,
    input  logic                               cpu_we,
    input  logic [PA_WIDTH-1:0]                cpu_addr,
    input  logic [WRD_WIDTH-1:0]               cpu_wdata,
    output logic                               cpu_ready,
    output logic                               cpu_hit,
    output logic [WRD_WIDTH-1:0]               cpu_rdata,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [PA_WIDTH-1:0]                mem_addr,
    output logic [WORDS_PER_BLK*WRD_WIDTH-1:0] mem_wblk,
    input  logic [WORDS_PER_BLK*WRD_WIDTH-1:0] mem_rblk,
    input  logic                               mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                        hit_cnt,
    output logic [31:0]                        miss_cnt
`endif
);
    localparam int BOFF = $clog2(WRD_WIDTH / 8);
    localparam int WOFF = $clog2(WORDS_PER_BLK);
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = PA_WIDTH - BOFF - WOFF - IDXW;
    localparam int HI_W = PA_WIDTH - BOFF;
    localparam int WSW  = (WOFF > 0) ? WOFF : 1;
    localparam int IXW  = (IDXW > 0) ? IDXW : 1;
    localparam int WYW  = $clog2(NWAYS);
    localparam int BLKW = WORDS_PER_BLK * WRD_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;
    state_t state, next_state;

    logic [HI_W-1:0]      r_line;
    logic                 r_we;
    logic [WRD_WIDTH-1:0] r_wdata;
    logic [WYW-1:0]       way_q;
    logic                 hit_q;

    logic [NWAYS-1:0] valid [NSETS];
    logic [NWAYS-1:0] dirty [NSETS];
    logic [WYW-1:0]   age   [NSETS][NWAYS];
    logic [TAGW-1:0]  tag_mem  [NSETS][NWAYS];
    logic [BLKW-1:0]  data_mem [NSETS][NWAYS];

    logic [WSW-1:0]  word_sel;
    logic [IXW-1:0]  idx;
    logic [TAGW-1:0] tag;

    // Byte-offset bits carry no information for full-word accesses.
    logic unused_addr;
    assign unused_addr = ^cpu_addr;

    assign word_sel = WSW'(r_line & HI_W'(WORDS_PER_BLK - 1));
    assign idx      = IXW'((r_line >> WOFF) & HI_W'(NSETS - 1));
    assign tag      = TAGW'(r_line >> (WOFF + IDXW));

    logic           hit;
    logic [WYW-1:0] hit_way;
    logic           inv_found;
    logic [WYW-1:0] inv_way;
    logic [WYW-1:0] lru_way;
    logic [WYW-1:0] vic_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WYW'(w);
            end
            if (!valid[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WYW'(w);
            end
            if (age[idx][w] == WYW'(NWAYS - 1))
                lru_way = WYW'(w);
        end
        vic_way = inv_found ? inv_way : lru_way;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (cpu_req) next_state = LOOKUP;
            LOOKUP: begin
                if (hit)
                    next_state = RESP;
                else if (valid[idx][vic_way] && dirty[idx][vic_way])
                    next_state = WRITEBACK;
                else
                    next_state = FILL;
            end
            WRITEBACK: if (mem_ack) next_state = FILL;
            FILL:      if (mem_ack) next_state = RESP;
            RESP:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            for (int s = 0; s < NSETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NWAYS; w++)
                    age[s][w] <= WYW'(w);
            end
        end else begin
            if (state == IDLE && cpu_req) begin
                r_line  <= cpu_addr[PA_WIDTH-1:BOFF];
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                hit_q <= hit;
                way_q <= hit ? hit_way : vic_way;
            end
            if (state == FILL && mem_ack) begin
                valid[idx][way_q] <= 1'b1;
                dirty[idx][way_q] <= 1'b0;
            end
            if (state == RESP) begin
                if (r_we)
                    dirty[idx][way_q] <= 1'b1;
                // Ages younger than the touched way shift up; the set stays a permutation.
                for (int w = 0; w < NWAYS; w++) begin
                    if (WYW'(w) == way_q)
                        age[idx][w] <= '0;
                    else if (age[idx][w] < age[idx][way_q])
                        age[idx][w] <= age[idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data_mem[idx][way_q] <= mem_rblk;
            tag_mem[idx][way_q]  <= tag;
        end else if (state == RESP && r_we) begin
            data_mem[idx][way_q][word_sel*WRD_WIDTH +: WRD_WIDTH] <= r_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESP) begin
            if (hit_q)
                hit_cnt <= hit_cnt + 32'd1;
            else
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

    logic [PA_WIDTH-1:0] wb_addr;
    logic [PA_WIDTH-1:0] fill_addr;
    assign wb_addr   = (PA_WIDTH'(tag_mem[idx][way_q]) << (IDXW + WOFF + BOFF))
                     | (PA_WIDTH'(idx) << (WOFF + BOFF));
    assign fill_addr = PA_WIDTH'(r_line >> WOFF) << (WOFF + BOFF);

    always_comb begin
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wblk  = '0;
        case (state)
            RESP: begin
                cpu_ready = 1'b1;
                cpu_hit   = hit_q;
                if (!r_we)
                    cpu_rdata = data_mem[idx][way_q][word_sel*WRD_WIDTH +: WRD_WIDTH];
            end
            WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wb_addr;
                mem_wblk = data_mem[idx][way_q];
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed self-checking bench for cache_ctrl_nway (honours CACHE_STATS_EN)
module tb_cache_ctrl_nway;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready, cpu_hit;
    logic [31:0]  cpu_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wblk, mem_rblk;
    logic         mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    cache_ctrl_nway dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wblk(mem_wblk), .mem_rblk(mem_rblk), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_model [logic [31:0]];
    int           n_txn;
    logic         log_we   [0:7];
    logic [31:0]  log_addr [0:7];
    logic [127:0] log_wblk [0:7];

    logic [31:0]  rd;
    logic         hit;
    int           ncyc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fetch(input logic [31:0] a);
        logic [127:0] r;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 4; w++)
            r[w*32 +: 32] = {8'(8'hA0 + w), a[23:0]};
        return r;
    endfunction

    // Issues one access and plays the memory side; ack arrives in the dly-th cycle of each mem_req.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, output logic [31:0] rdata, output logic hit_o,
                          output int cyc);
        int  reqcnt = 0;
        logic done = 1'b0;
        n_txn = 0;
        rdata = '0;
        hit_o = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cyc = 0;
        while (!done && cyc <= 100) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                reqcnt  = 0;
            end
            if (cpu_ready) begin
                rdata = cpu_rdata;
                hit_o = cpu_hit;
                done  = 1'b1;
            end else begin
                if (mem_req) begin
                    if (reqcnt == 0 && n_txn < 8) begin
                        log_we[n_txn]   = mem_we;
                        log_addr[n_txn] = mem_addr;
                        log_wblk[n_txn] = mem_wblk;
                        n_txn++;
                        if (mem_we) mem_model[mem_addr] = mem_wblk;
                    end
                    reqcnt++;
                    if (reqcnt >= dly) begin
                        mem_ack  = 1'b1;
                        mem_rblk = mem_we ? '0 : fetch(mem_addr);
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("ready_seen", done, 1'b1);
    endtask

    initial begin
        logic [127:0] blk;
        int           seen;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rblk = '0;
        blk = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        mem_model[32'h100] = blk;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_hit",   cpu_hit,   1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wblk",  mem_wblk,  128'h0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt",   hit_cnt,   32'h0);
`endif
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_req",   mem_req,   1'b0);
        check("stray_ack_ready", cpu_ready, 1'b0);

        // Cold miss, then hit
        access(1'b0, 32'h104, 0, 3, rd, hit, ncyc);
        check("cold_ntxn", n_txn, 1);
        check("cold_mem_we", log_we[0], 1'b0);
        check("cold_mem_addr", log_addr[0], 32'h100);
        check("cold_rdata", rd, 32'h22222222);
        check("cold_hit", hit, 1'b0);
        check("cold_latency", ncyc, 4);
        access(1'b0, 32'h104, 0, 1, rd, hit, ncyc);
        check("rehit_hit", hit, 1'b1);
        check("rehit_latency", ncyc, 1);
        check("rehit_ntxn", n_txn, 0);

        access(1'b1, 32'h104, 32'hDEADBEEF, 1, rd, hit, ncyc);
        check("store_hit", hit, 1'b1);
        access(1'b0, 32'h104, 0, 1, rd, hit, ncyc);
        check("load_after_store", rd, 32'hDEADBEEF);
        check("load_after_store_hit", hit, 1'b1);

        // Fill set 0, make 0x200 the oldest
        access(1'b0, 32'h200, 0, 1, rd, hit, ncyc);
        check("ld200", rd, 32'hA0000200);
        access(1'b0, 32'h300, 0, 2, rd, hit, ncyc);
        access(1'b0, 32'h400, 0, 1, rd, hit, ncyc);
        access(1'b1, 32'h104, 32'hDEADBEEF, 1, rd, hit, ncyc);
        access(1'b0, 32'h500, 0, 1, rd, hit, ncyc);
        check("ld500_ntxn", n_txn, 1);
        check("ld500_fill", log_addr[0], 32'h500);
        access(1'b0, 32'h204, 0, 1, rd, hit, ncyc);
        check("200_evicted", hit, 1'b0);
        // That reload took way of 0x300 (oldest); restore ages by reloading 0x300 path
        access(1'b0, 32'h304, 0, 1, rd, hit, ncyc);
        check("300_evicted", hit, 1'b0);
        access(1'b0, 32'h104, 0, 1, rd, hit, ncyc);
        check("100_protected", hit, 1'b1);
        check("100_data", rd, 32'hDEADBEEF);

        // Dirty eviction: ways are 0x100(age0,dirty) 0x500 0x200 0x300; push 0x100 out
        access(1'b0, 32'h800, 0, 1, rd, hit, ncyc);
        access(1'b0, 32'h900, 0, 1, rd, hit, ncyc);
        access(1'b0, 32'hA00, 0, 1, rd, hit, ncyc);
        check("a00_no_wb", n_txn, 1);
        access(1'b0, 32'hB00, 0, 2, rd, hit, ncyc);
        check("wb_ntxn", n_txn, 2);
        check("wb_we", log_we[0], 1'b1);
        check("wb_addr", log_addr[0], 32'h100);
        check("wb_word1", log_wblk[0][63:32], 32'hDEADBEEF);
        check("wb_word0", log_wblk[0][31:0], 32'h11111111);
        check("wb_then_fill_we", log_we[1], 1'b0);
        check("wb_then_fill_addr", log_addr[1], 32'hB00);
        check("b00_rdata", rd, 32'hA0000B00);

        // Store miss allocates
        access(1'b1, 32'h708, 32'hCAFEF00D, 1, rd, hit, ncyc);
        check("stmiss_hit", hit, 1'b0);
        check("stmiss_fill", log_addr[0], 32'h700);
        access(1'b0, 32'h708, 0, 1, rd, hit, ncyc);
        check("stmiss_reload_hit", hit, 1'b1);
        check("stmiss_reload_data", rd, 32'hCAFEF00D);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 32'hC00 + 32'(i) * 32'h100, 0, 1, rd, hit, ncyc);
            if (n_txn == 2 && log_we[0] && log_addr[0] == 32'h700) begin
                seen++;
                check("708_wb_word2", log_wblk[0][95:64], 32'hCAFEF00D);
            end
        end
        check("708_wb_seen", seen, 1);

        access(1'b0, 32'h104, 0, 1, rd, hit, ncyc);
        check("refetch_100_hit", hit, 1'b0);
        check("refetch_100_data", rd, 32'hDEADBEEF);
        access(1'b0, 32'h1234, 0, 1, rd, hit, ncyc);
        check("set3_fill", log_addr[0], 32'h1230);
        check("set3_data", rd, 32'hA1001230);

        // Reset during FILL
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2040;
        @(negedge clk);
        cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (mem_req && !mem_we) seen = 1;
            else @(negedge clk);
        end
        check("midfill_req_seen", seen, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midfill_req_drop", mem_req, 1'b0);
        check("midfill_no_ready", cpu_ready, 1'b0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_ready) seen++;
        end
        check("midfill_no_late_ready", seen, 0);

        access(1'b0, 32'h104, 0, 2, rd, hit, ncyc);
        check("post_rst_miss", hit, 1'b0);
        check("post_rst_data", rd, 32'hDEADBEEF);
        access(1'b0, 32'h104, 0, 1, rd, hit, ncyc);
        check("post_rst_hit", hit, 1'b1);
        access(1'b0, 32'h204, 0, 1, rd, hit, ncyc);
        check("post_rst_204", rd, 32'hA1000200);
        access(1'b0, 32'h204, 0, 1, rd, hit, ncyc);
        check("post_rst_204_hit", hit, 1'b1);
        access(1'b0, 32'h304, 0, 1, rd, hit, ncyc);
        check("post_rst_304_hit", hit, 1'b0);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("hit_cnt", hit_cnt, 32'd2);
        check("miss_cnt", miss_cnt, 32'd3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
